// File: rtl/mod_timer_arbiter.sv
// Round-robin arbiter that lends one shared modulus counter to N_REQ requesters.
// The winner counts up to its latched length on tick_en, gets a done pulse, then the block re-arbitrates.
module mod_timer_arbiter #(
    parameter int N_REQ = 4,
    parameter int CW    = 8,
    parameter int IDXW  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*CW-1:0]   len,
    input  logic                  tick_en,
    output logic [N_REQ-1:0]      grant,
    output logic                  busy,
    output logic [CW-1:0]         count,
    output logic [N_REQ-1:0]      done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             busy_q, busy_d;
    logic [CW-1:0]    count_q, count_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic [IDXW-1:0]  win_q, win_d;
    logic [CW-1:0]    mod_len_q, mod_len_d;

    logic [CW-1:0]    len_arr [N_REQ];
    logic             found;
    logic [IDXW-1:0]  pick;
    logic [IDXW-1:0]  ptr_after;
    logic             last_tick;

    for (genvar i = 0; i < N_REQ; i++) begin : g_len
        assign len_arr[i] = len[i*CW +: CW];
    end

    function automatic logic [N_REQ-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First set request bit at or above ptr_q, wrapping past N_REQ-1 to 0.
    always_comb begin
        int              p;
        logic [IDXW-1:0] pidx;
        found = 1'b0;
        pick  = '0;
        p     = 0;
        pidx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            p = int'(ptr_q) + k;
            if (p >= N_REQ) begin
                p = p - N_REQ;
            end
            pidx = IDXW'(p);
            if (!found && req[pidx]) begin
                found = 1'b1;
                pick  = pidx;
            end
        end
    end

    assign ptr_after = (win_q == IDXW'(N_REQ - 1)) ? '0 : win_q + IDXW'(1);

    // mod_len of zero wraps to all-ones here, giving the full 2^CW modulus.
    assign last_tick = tick_en && (count_q == mod_len_q - CW'(1));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        count_d   = count_q;
        done_d    = '0;
        ptr_d     = ptr_q;
        win_d     = win_q;
        mod_len_d = mod_len_q;
        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
                if (found) begin
                    state_d   = S_RUN;
                    win_d     = pick;
                    mod_len_d = len_arr[pick];
                    grant_d   = onehot(pick);
                    busy_d    = 1'b1;
                end
            end
            S_RUN: begin
                if (!req[win_q]) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
                    ptr_d   = ptr_after;
                end else if (last_tick) begin
                    state_d = S_DONE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
                    done_d  = onehot(win_q);
                end else if (tick_en) begin
                    count_d = count_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ptr_d   = ptr_after;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            count_q   <= '0;
            done_q    <= '0;
            ptr_q     <= '0;
            win_q     <= '0;
            mod_len_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            done_q    <= done_d;
            ptr_q     <= ptr_d;
            win_q     <= win_d;
            mod_len_q <= mod_len_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign count = count_q;
    assign done  = done_q;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant_q));
    a_done_onehot0:  assert property (@(posedge clk) disable iff (!rst) $onehot0(done_q));
    a_no_overlap:    assert property (@(posedge clk) disable iff (!rst) !(|grant_q && |done_q));
    a_busy_grant:    assert property (@(posedge clk) disable iff (!rst) busy_q == |grant_q);

endmodule
